mem_bus_controller: RTL and testbench

Main-memory slave on the shared common bus behind the multi-core MESI caches and the arbiter.
- Reads: serves bus reads from a word array after a fixed latency; requests the bus through the arbiter's memory snoop port (Mem_snoop_req / Mem_snoop_gnt); drives returned data onto the common data bus.
- Writes: accepts write-backs of modified blocks and signals completion with Mem_write_done.
- Aborts: when a snooping cache supplies the data instead, Mem_oprn_abort cancels a pending read.

---
 rtl/mem_bus_pkg.sv | 30 +++
 rtl/mem_array_sp.sv | 34 +++
 rtl/mem_bus_controller.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the main-memory bus slave and the agents that talk to
// it (caches, bench):
//   mem_state_t  - controller FSM state encoding
//   MEM_LAT_MAX  - largest legal MEM_LATENCY
//   CNT_W        - width of the latency down-counter
//   word_idx()   - byte address -> word index, with address aliasing applied
// -----------------------------------------------------------------------------
package mem_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_REQ,
      ST_RD_DRIVE,
      ST_WR_WAIT,
      ST_WR_DONE
   } mem_state_t;

   localparam int MEM_LAT_MAX = 255;
   localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

   // Drops the byte offset and every bit above the array's index width, so
   // addresses alias modulo the array depth. addr_w must be below 31.
   function automatic logic [31:0] word_idx(input logic [31:0] addr, input int addr_w);
      return (addr >> 2) & ((32'd1 << addr_w) - 32'd1);
   endfunction

endpackage

// File: rtl/mem_array_sp.sv
// -----------------------------------------------------------------------------
// mem_array_sp
// Single-port word array: synchronous write, asynchronous read on the same
// address.
//   clk      in   clock
//   we_i     in   write enable, captured on the rising edge
//   addr_i   in   word address (read and write)
//   wdata_i  in   write data
//   rdata_o  out  combinational read data at addr_i
// -----------------------------------------------------------------------------
module mem_array_sp #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   // NOTE: the storage array is deliberately not reset; clearing it would need
   // a per-word reset and memory contents must survive a bus reset anyway.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_bus_controller.sv
// -----------------------------------------------------------------------------
// mem_bus_controller
// Main-memory slave on the shared common bus. A read waits MEM_LATENCY cycles,
// requests the bus from the arbiter and drives one data beat; a snooping cache
// may abort it before the drive. A write-back waits MEM_LATENCY cycles, commits
// and pulses Mem_write_done. Requests arriving while busy are dropped.
//
// Optional build macro MEM_PROTOCOL_CHECK_EN adds a sticky Mem_err output that
// flags bus protocol violations (request while busy, stray grant, stray abort).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   Mem_rd, Mem_wr     read / write-back request (Mem_wr wins if both)
//   Mem_oprn_abort     cancel a pending read
//   Address_Com        byte address, word index = Address_Com[ADDR_W+1:2]
//   Data_Bus_Com_in    write data
//   Data_Bus_Com_out   read data, zero when not driving
//   Data_Bus_Com_oe    tri-state enable for the read data
//   Data_in_Bus        read data valid
//   Mem_write_done     one-cycle write commit pulse
//   Mem_snoop_req      bus request to the arbiter
//   Mem_snoop_gnt      arbiter grant
//   Mem_err            sticky protocol error (MEM_PROTOCOL_CHECK_EN only)
// -----------------------------------------------------------------------------
module mem_bus_controller
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int MEM_LATENCY = 4,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Mem_rd,
   input  logic              Mem_wr,
   input  logic              Mem_oprn_abort,
   input  logic [31:0]       Address_Com,
   input  logic [DATA_W-1:0] Data_Bus_Com_in,
   output logic [DATA_W-1:0] Data_Bus_Com_out,
   output logic              Data_Bus_Com_oe,
   output logic              Data_in_Bus,
   output logic              Mem_write_done,
`ifdef MEM_PROTOCOL_CHECK_EN
   output logic              Mem_err,
`endif
   output logic              Mem_snoop_req,
   input  logic              Mem_snoop_gnt
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

   mem_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              req_q, req_d;
   logic              drive_q, drive_d;
   logic              done_q, done_d;
   logic              mem_we;
   logic [ADDR_W-1:0] req_idx;
   logic [DATA_W-1:0] mem_rdata;

   assign req_idx = ADDR_W'(word_idx(Address_Com, ADDR_W));

   mem_array_sp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mem_we  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Mem_wr) begin
               addr_d  = req_idx;
               wdata_d = Data_Bus_Com_in;
               cnt_d   = LAT_M1;
               state_d = ST_WR_WAIT;
            end else if (Mem_rd) begin
               addr_d  = req_idx;
               cnt_d   = LAT_M1;
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (Mem_oprn_abort)   state_d = ST_IDLE;
            else if (cnt_q == '0) state_d = ST_RD_REQ;
            else                  cnt_d   = cnt_q - 1'b1;
         end
         ST_RD_REQ: begin
            // Abort outranks a same-cycle grant: a cache already owns the data.
            if (Mem_oprn_abort)     state_d = ST_IDLE;
            else if (Mem_snoop_gnt) state_d = ST_RD_DRIVE;
         end
         ST_RD_DRIVE: state_d = ST_IDLE;
         ST_WR_WAIT: begin
            // Aborts are ignored here: a write-back must always land.
            if (cnt_q == '0) begin
               mem_we  = ~rst;
               state_d = ST_WR_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WR_DONE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they are glitch-free
      // and line up with the state they belong to.
      req_d   = (state_d == ST_RD_REQ);
      drive_d = (state_d == ST_RD_DRIVE);
      done_d  = (state_d == ST_WR_DONE);
      dout_d  = drive_d ? mem_rdata : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // updates from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         req_q   <= 1'b0;
         drive_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         req_q   <= req_d;
         drive_q <= drive_d;
         done_q  <= done_d;
      end
   end

   assign Data_Bus_Com_out = dout_q;
   assign Data_Bus_Com_oe  = drive_q;
   assign Data_in_Bus      = drive_q;
   assign Mem_write_done   = done_q;
   assign Mem_snoop_req    = req_q;

`ifdef MEM_PROTOCOL_CHECK_EN
   logic err_q;
   logic proto_viol;

   always_comb begin
      proto_viol = ((Mem_rd || Mem_wr) && (state_q != ST_IDLE))
                || (Mem_snoop_gnt && (state_q != ST_RD_REQ))
                || (Mem_oprn_abort && (state_q inside {ST_IDLE, ST_WR_WAIT, ST_WR_DONE}));
   end

   always_ff @(posedge clk) begin
      if (rst)             err_q <= 1'b0;
      else if (proto_viol) err_q <= 1'b1;
   end

   assign Mem_err = err_q;

   a_protocol : assert property (@(posedge clk) disable iff (rst) !proto_viol)
      else $error("mem_bus_controller: protocol violation in state %s", state_q.name());
`endif

endmodule

// File: tb/tb_mem_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_controller
// Drives read/write transactions (directed, then random) into the memory
// controller. A reference memory and the expected event timeline are derived
// from the bus protocol timing: a write commit pulses L+1 cycles after the
// request, a read asks for the bus from cycle L+1 until the grant and drives
// data one cycle after the grant. Expected events go into a scoreboard queue
// that an independent monitor drains as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_mem_bus_controller;

   localparam int ADDR_W      = 14;
   localparam int MEM_LATENCY = 4;
   localparam int DATA_W      = 32;
   localparam int L           = MEM_LATENCY;
   localparam int DEPTH       = 1 << ADDR_W;

   typedef struct {
      bit                is_wr;
      int                cyc;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              Mem_rd, Mem_wr, Mem_oprn_abort, Mem_snoop_gnt;
   logic [31:0]       Address_Com;
   logic [DATA_W-1:0] Data_Bus_Com_in;
   logic [DATA_W-1:0] Data_Bus_Com_out;
   logic              Data_Bus_Com_oe, Data_in_Bus, Mem_write_done, Mem_snoop_req;
`ifdef MEM_PROTOCOL_CHECK_EN
   logic              Mem_err;
`endif

   int                cyc      = 0;
   int                n_checks = 0;
   int                n_errs   = 0;
   bit                mon_en   = 1'b0;
   exp_t              sb[$];
   bit                exp_req[int];
   logic [DATA_W-1:0] mdl[int];
   int                keys[$];

   mem_bus_controller #(
      .ADDR_W      (ADDR_W),
      .MEM_LATENCY (MEM_LATENCY),
      .DATA_W      (DATA_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .Mem_rd           (Mem_rd),
      .Mem_wr           (Mem_wr),
      .Mem_oprn_abort   (Mem_oprn_abort),
      .Address_Com      (Address_Com),
      .Data_Bus_Com_in  (Data_Bus_Com_in),
      .Data_Bus_Com_out (Data_Bus_Com_out),
      .Data_Bus_Com_oe  (Data_Bus_Com_oe),
      .Data_in_Bus      (Data_in_Bus),
      .Mem_write_done   (Mem_write_done),
`ifdef MEM_PROTOCOL_CHECK_EN
      .Mem_err          (Mem_err),
`endif
      .Mem_snoop_req    (Mem_snoop_req),
      .Mem_snoop_gnt    (Mem_snoop_gnt)
   );

   always #5 clk = ~clk;

   // Cycle k spans rising edge k to rising edge k+1; inputs driven at the
   // falling edge inside cycle k are sampled at its closing edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic int word_of(input logic [31:0] addr);
      return int'((addr / 32'd4) % 32'(DEPTH));
   endfunction

   // A byte address for word idx with random byte offset and random aliasing.
   function automatic logic [31:0] alias_addr(input int idx);
      return 32'(idx) * 32'd4 + 32'($urandom_range(0, 3))
           + 32'($urandom_range(0, 65535)) * 32'd65536;
   endfunction

   task automatic idle_inputs();
      Mem_rd          = 1'b0;
      Mem_wr          = 1'b0;
      Mem_oprn_abort  = 1'b0;
      Mem_snoop_gnt   = 1'b0;
      rst             = 1'b0;
      Address_Com     = '0;
      Data_Bus_Com_in = '0;
   endtask

   // Write-back. kill_at>0 pulses rst in that cycle (1..L-1 loses the write,
   // L+1 lands in the done cycle). rd_poke raises Mem_rd in cycle 1.
   task automatic do_write(input logic [31:0] addr, input logic [DATA_W-1:0] data,
                           input int kill_at, input bit both, input bit rd_poke);
      int c0, last, idx;
      bit killed;
      c0     = cyc;
      idx    = word_of(addr);
      killed = (kill_at > 0) && (kill_at <= L);
      if (!killed) begin
         sb.push_back('{1'b1, c0 + L + 1, '0});
         if (!mdl.exists(idx)) keys.push_back(idx);
         mdl[idx] = data;
      end
      last = killed ? c0 + kill_at : c0 + L + 1;
      for (int k = c0; k <= last; k++) begin
         if (k > c0) @(negedge clk);
         Mem_wr          = (k == c0);
         Mem_rd          = ((k == c0) && both) || ((k == c0 + 1) && rd_poke);
         Address_Com     = (k == c0) ? addr : $urandom;
         Data_Bus_Com_in = (k == c0) ? data : DATA_W'($urandom);
         rst             = (kill_at > 0) && (k == c0 + kill_at);
`ifdef MEM_PROTOCOL_CHECK_EN
         if (rd_poke && (k == c0 + 2)) check("mem_err", 32'(Mem_err), 32'd1);
`endif
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // Read. Grant arrives dly cycles after the bus request rises. kill_at>0
   // raises abort (or rst when kill_rst) in that cycle.
   task automatic do_read(input logic [31:0] addr, input int dly,
                          input int kill_at, input bit kill_rst);
      int c0, last, gnt_cyc, idx;
      bit killed, hit;
      c0      = cyc;
      idx     = word_of(addr);
      gnt_cyc = c0 + L + 1 + dly;
      killed  = (kill_at > 0) && (kill_at <= L + 1 + dly);
      for (int k = c0 + L + 1; k <= gnt_cyc; k++) begin
         if (!killed || (k <= c0 + kill_at)) exp_req[k] = 1'b1;
      end
      if (!killed) sb.push_back('{1'b0, gnt_cyc + 1, mdl[idx]});
      last = killed ? c0 + kill_at : gnt_cyc + 1;
      for (int k = c0; k <= last; k++) begin
         if (k > c0) @(negedge clk);
         hit            = (kill_at > 0) && (k == c0 + kill_at);
         Mem_rd         = (k == c0);
         Address_Com    = (k == c0) ? addr : $urandom;
         Mem_snoop_gnt  = (k == gnt_cyc);
         Mem_oprn_abort = hit && !kill_rst;
         rst            = hit && kill_rst;
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // Monitor: per-cycle bus-request and output-idle checks, plus scoreboard
   // matching whenever the DUT presents read data or a write completion.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("snoop_req", 32'(Mem_snoop_req), 32'(exp_req.exists(cyc)));
            check("oe_vs_valid", 32'(Data_Bus_Com_oe), 32'(Data_in_Bus));
            if (Data_Bus_Com_oe !== 1'b1) check("out_idle_zero", Data_Bus_Com_out, '0);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
               check("missed_event", 32'(cyc), 32'(sb[0].cyc));
               void'(sb.pop_front());
            end
            if (Data_in_Bus === 1'b1 || Mem_write_done === 1'b1) begin
               if (sb.size() == 0) begin
                  check("unexpected_event", {30'd0, Data_in_Bus, Mem_write_done}, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("event_cycle", 32'(cyc), 32'(e.cyc));
                  check("event_kind", 32'(Mem_write_done), 32'(e.is_wr));
                  if (!e.is_wr) check("rd_data", Data_Bus_Com_out, e.data);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rk, ridx, rdly;
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Write then read, grant immediately and after a delay.
      do_write(32'h0000_0004, 32'hcafe_cafe, 0, 1'b0, 1'b0);
      do_read(32'h0000_0004, 0, 0, 1'b0);
      do_read(32'h0000_0004, 3, 0, 1'b0);
      // Abort in RD_WAIT cycle 2, new read issued in cycle 4.
      do_read(32'h0000_0004, 0, 2, 1'b0);
      @(negedge clk);
      do_read(32'h0000_0004, 1, 0, 1'b0);
      // Abort in the same cycle as the grant.
      do_read(32'h0000_0004, 1, L + 2, 1'b0);
      // Read+write together is a write; aliased address.
      do_write(32'h0001_0004, 32'hbead_bead, 0, 1'b1, 1'b0);
      do_read(32'h0000_0004, 0, 0, 1'b0);
      // Reset in WR_WAIT cycle 2 with an ignored read poke: write is lost.
      do_write(32'h0000_0004, 32'hdead_beef, 2, 1'b0, 1'b1);
      do_read(32'h0000_0004, 0, 0, 1'b0);
      // Abort during RD_DRIVE is ignored; reset during RD_REQ kills the read.
      do_read(32'h0000_0004, 2, L + 4, 1'b0);
      do_read(32'h0000_0004, 2, L + 2, 1'b1);
      // Reset in WR_DONE: the write has already committed.
      do_write(32'h0000_0004, 32'h1234_5678, L + 1, 1'b0, 1'b0);
      do_read(32'h0000_0004, 0, 0, 1'b0);

      for (int t = 0; t < 150; t++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         rk = 0;
         if ($urandom_range(0, 9) < 4) begin
            ridx = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, L - 1) : L + 1;
            do_write(alias_addr(ridx), DATA_W'($urandom), rk, 1'($urandom_range(0, 1)), 1'b0);
         end else begin
            rdly = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) rk = $urandom_range(1, L + 2 + rdly);
            ridx = keys[$urandom_range(0, keys.size() - 1)];
            do_read(alias_addr(ridx), rdly, rk, 1'($urandom_range(0, 1)));
         end
      end

      repeat (6) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
